ctrl_state_reg: RTL and testbench
=================================

Name: ctrl_state_reg

Overview:
- Holds the multicycle CPU's current control state and turns it into per-cycle datapath control strobes.
- Sits directly downstream of the next-state function. It registers that block's next_state each clock and feeds the registered state back to it as i_state.
- Also keeps a retired-instruction counter and a sticky halt flag.

Parameters:
CNT_W, 32, width of retired-instruction counter
HALT_OP, 6'b111111, opcode that halts the core

Ports:
CLK  in  1  core clock, rising edge
Reset  in  1  synchronous reset, active-low
next_state  in  3  state chosen by next-state function
opcode  in  6  IR[31:26]; stable from ID until next IF
zero  in  1  ALU zero flag (valid in bEXE)
stall  in  1  memory/bus not ready; freeze state
i_state  out  3  registered current state (to next-state function)
PCWre  out  1  PC write enable
IRWre  out  1  instruction register write enable
mRD  out  1  data memory read
mWR  out  1  data memory write
RegWre  out  1  register file write enable
PCSrc  out  2  00 PC+4, 01 branch target, 10 jr (rs), 11 jump target
WrRegDSrc  out  1  1 = memory data to rd/rt, 0 = ALU result
halted  out  1  sticky: core stopped
retired  out  CNT_W  instructions completed since reset

Behaviour:
- State encodings (3 bits): IF 000, ID 001, aEXE 110, bEXE 101, cEXE 010, MEM 011, aWB 111, cWB 100.
- Reset (Reset==0 at posedge CLK):
  - i_state<=IF, halted<=0, retired<=0.
  - Outputs during reset: all strobes 0, PCSrc=00, WrRegDSrc=0. Reset overrides stall.
- Normal posedge (Reset==1):
  - stall=0 and halted=0: i_state<=next_state.
  - stall=1 or halted=1: i_state holds.
- Strobe gating: strobes are combinational from i_state and opcode. All write/read strobes (PCWre, IRWre, mRD, mWR, RegWre) are forced 0 while stall=1 or halted=1.
- Strobe decode (ungated):
  - IRWre=1 in IF.
  - mRD=1 in MEM when opcode==110001 (lw).
  - mWR=1 in MEM when opcode==110000 (sw).
  - RegWre=1 in aWB and cWB, and in ID when opcode==111010 (jal, writes $31).
  - WrRegDSrc=1 only in cWB.
- PCWre=1 in the final state of every instruction:
  - ID when opcode[5:3]==111 and opcode!=HALT_OP;
  - bEXE;
  - MEM when opcode!=110001;
  - aWB;
  - cWB.
- PCSrc:
  - 01 in bEXE when zero==1;
  - 10 in ID for opcode 111001;
  - 11 in ID for 111000/111010;
  - else 00.
- Retirement: retired increments by 1 on each posedge where PCWre==1 (after gating). It wraps modulo 2^CNT_W.
- Halt: in ID with opcode==HALT_OP, halted<=1 at the next posedge. i_state then holds ID permanently, since halted blocks state update; the IF it would have advanced to is never entered. No PC write and no retire count for halt. Only Reset clears halted.
- Simultaneous events:
  - stall and halt decode in the same cycle: halt is not latched until stall drops.
  - Reset mid-instruction: abandon the instruction; no strobe asserted that cycle.
- Undefined i_state values cannot occur after reset; decode them as all-strobes-0.

Decomposition:
- Shared package cpu_ctrl_pkg: 3-bit state constants (IF..cWB) and opcode constants (OP_LW, OP_SW, OP_BEQ=110100, OP_J, OP_JR, OP_JAL, OP_HALT). The next-state function uses the same constants.
- One sub-module, ctrl_decode: purely combinational strobe/PCSrc decode from (i_state, opcode, zero). The top level holds the state register, gating, halt flag and counter.

Test Plan:
- Reset held 0 for 2 cycles, then released, with next_state=001 -> i_state=000, all strobes 0, retired=0; one posedge after release i_state=001.
- add (000000) walk IF->ID->aEXE->aWB->IF -> IRWre only in IF; RegWre=1 and PCWre=1 only in aWB; retired 0->1.
- lw (110001) through cEXE->MEM->cWB with stall=1 for 3 cycles in MEM -> i_state stays 011 and mRD=0 while stalled; mRD=1 the cycle after release; WrRegDSrc=1 and PCWre=1 in cWB.
- beq (110100) in bEXE: zero=1 -> PCSrc=01, PCWre=1; repeat with zero=0 -> PCSrc=00, PCWre=1.
- jal (111010) in ID -> RegWre=1, PCSrc=11, PCWre=1, retired+1.
- HALT (111111) in ID -> halted=1 next cycle; i_state frozen at 001; strobes stay 0 and retired unchanged for 20 cycles; Reset=0 then clears halted and returns i_state to 000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control path.
// The state encodings and opcode values are common to the next-state
// function and to ctrl_state_reg / ctrl_decode, so they live here once.
package cpu_ctrl_pkg;

    // Control states (3-bit encoding fixed by the next-state function)
    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_AEXE = 3'b110,
        ST_BEXE = 3'b101,
        ST_CEXE = 3'b010,
        ST_MEM  = 3'b011,
        ST_AWB  = 3'b111,
        ST_CWB  = 3'b100
    } ctrl_state_e;

    // Opcodes (IR[31:26]) that the control path cares about
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // PC source selector values
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JR     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Jump-class instructions (opcode[5:3]==111) finish in ID
    function automatic logic is_jump_class(input logic [5:0] op);
        return (op[5:3] == 3'b111);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational strobe decode for the multicycle control path.
// Ports:
//   i_state        current registered control state
//   i_opcode       IR[31:26]
//   i_zero         ALU zero flag (meaningful in bEXE)
//   o_pc_wre       PC write enable (last state of each instruction)
//   o_ir_wre       IR write enable
//   o_m_rd/o_m_wr  data memory read / write
//   o_reg_wre      register file write enable
//   o_pc_src       PC source select
//   o_wr_reg_d_src 1 = memory data to register file
//   o_halt_dec     halt opcode seen in ID
// Outputs are ungated; stall/halt/reset gating happens in the top level.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic [2:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output logic       o_pc_wre,
    output logic       o_ir_wre,
    output logic       o_m_rd,
    output logic       o_m_wr,
    output logic       o_reg_wre,
    output logic [1:0] o_pc_src,
    output logic       o_wr_reg_d_src,
    output logic       o_halt_dec
);

    // Decode state + opcode into raw strobes; unknown states give all zeros
    always_comb begin
        o_pc_wre       = 1'b0;
        o_ir_wre       = 1'b0;
        o_m_rd         = 1'b0;
        o_m_wr         = 1'b0;
        o_reg_wre      = 1'b0;
        o_pc_src       = PCSRC_SEQ;
        o_wr_reg_d_src = 1'b0;
        o_halt_dec     = 1'b0;
        case (i_state)
            ST_IF: begin
                o_ir_wre = 1'b1;
            end
            ST_ID: begin
                // Jumps complete here; halt does not write the PC
                o_pc_wre   = is_jump_class(i_opcode) && (i_opcode != HALT_OP);
                o_reg_wre  = (i_opcode == OP_JAL);
                o_halt_dec = (i_opcode == HALT_OP);
                if (i_opcode == OP_JR) begin
                    o_pc_src = PCSRC_JR;
                end else if ((i_opcode == OP_J) || (i_opcode == OP_JAL)) begin
                    o_pc_src = PCSRC_JUMP;
                end else begin
                    o_pc_src = PCSRC_SEQ;
                end
            end
            ST_BEXE: begin
                o_pc_wre = 1'b1;
                if (i_zero) begin
                    o_pc_src = PCSRC_BRANCH;
                end else begin
                    o_pc_src = PCSRC_SEQ;
                end
            end
            ST_MEM: begin
                o_m_rd = (i_opcode == OP_LW);
                o_m_wr = (i_opcode == OP_SW);
                // lw continues to cWB; every other memory op ends here
                o_pc_wre = (i_opcode != OP_LW);
            end
            ST_AWB: begin
                o_reg_wre = 1'b1;
                o_pc_wre  = 1'b1;
            end
            ST_CWB: begin
                o_reg_wre      = 1'b1;
                o_pc_wre       = 1'b1;
                o_wr_reg_d_src = 1'b1;
            end
            ST_AEXE, ST_CEXE: begin
                o_pc_src = PCSRC_SEQ;
            end
            default: begin
                o_pc_src = PCSRC_SEQ;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_state_reg.sv
// Control state register of the multicycle CPU.
// Registers next_state from the next-state function, feeds it back as
// i_state, gates the decoded strobes with stall/halt/reset, keeps a
// sticky halt flag and a retired-instruction counter.
// Ports:
//   CLK, Reset (sync, active-low)
//   next_state, opcode, zero, stall     inputs from datapath / next-state fn
//   i_state                             registered state
//   PCWre, IRWre, mRD, mWR, RegWre      gated strobes
//   PCSrc, WrRegDSrc                    selectors (zeroed during reset)
//   halted, retired                     status
module ctrl_state_reg
    import cpu_ctrl_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [2:0]       next_state,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             stall,
    output logic [2:0]       i_state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             mRD,
    output logic             mWR,
    output logic             RegWre,
    output logic [1:0]       PCSrc,
    output logic             WrRegDSrc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]       r_state;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    logic             w_pc_wre;
    logic             w_ir_wre;
    logic             w_m_rd;
    logic             w_m_wr;
    logic             w_reg_wre;
    logic [1:0]       w_pc_src;
    logic             w_wr_reg_d_src;
    logic             w_halt_dec;
    logic             w_freeze;
    logic             w_active;

    ctrl_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .i_state        (r_state),
        .i_opcode       (opcode),
        .i_zero         (zero),
        .o_pc_wre       (w_pc_wre),
        .o_ir_wre       (w_ir_wre),
        .o_m_rd         (w_m_rd),
        .o_m_wr         (w_m_wr),
        .o_reg_wre      (w_reg_wre),
        .o_pc_src       (w_pc_src),
        .o_wr_reg_d_src (w_wr_reg_d_src),
        .o_halt_dec     (w_halt_dec)
    );

    // Reset abandons the current instruction, so it also kills strobes
    assign w_freeze = stall | r_halted;
    assign w_active = Reset & ~w_freeze;

    assign PCWre     = w_active & w_pc_wre;
    assign IRWre     = w_active & w_ir_wre;
    assign mRD       = w_active & w_m_rd;
    assign mWR       = w_active & w_m_wr;
    assign RegWre    = w_active & w_reg_wre;
    assign PCSrc     = Reset ? w_pc_src : PCSRC_SEQ;
    assign WrRegDSrc = Reset & w_wr_reg_d_src;

    assign i_state = r_state;
    assign halted  = r_halted;
    assign retired = r_retired;

    // State register, sticky halt flag and retired-instruction counter
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state   <= ST_IF;
            r_halted  <= 1'b0;
            r_retired <= {CNT_W{1'b0}};
        end else begin
            // A halt in ID keeps the core parked in ID rather than IF
            if (!w_freeze && !w_halt_dec) begin
                r_state <= next_state;
            end else begin
                r_state <= r_state;
            end
            if (w_active && w_halt_dec) begin
                r_halted <= 1'b1;
            end else begin
                r_halted <= r_halted;
            end
            if (PCWre) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_retired <= r_retired;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_state_reg.sv
// Scoreboard bench for ctrl_state_reg: each stimulus cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_ctrl_state_reg;
    import cpu_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [2:0]  next_state;
    logic [5:0]  opcode;
    logic        zero;
    logic        stall;
    logic [2:0]  i_state;
    logic        PCWre, IRWre, mRD, mWR, RegWre;
    logic [1:0]  PCSrc;
    logic        WrRegDSrc;
    logic        halted;
    logic [31:0] retired;

    always #5 CLK = ~CLK;

    ctrl_state_reg #(.CNT_W(32), .HALT_OP(6'b111111)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .next_state (next_state),
        .opcode     (opcode),
        .zero       (zero),
        .stall      (stall),
        .i_state    (i_state),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .mRD        (mRD),
        .mWR        (mWR),
        .RegWre     (RegWre),
        .PCSrc      (PCSrc),
        .WrRegDSrc  (WrRegDSrc),
        .halted     (halted),
        .retired    (retired)
    );

    // expected = {state[2:0], {PCWre,IRWre,mRD,mWR,RegWre}, PCSrc, WrRegDSrc, halted, retired[31:0]}
    logic [43:0] exp_q[$];
    int          id_q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec_n  = 0;

    logic [43:0] m_exp;
    logic [43:0] m_act;
    int          m_id;

    // Apply one cycle of inputs and queue the outputs expected in that cycle
    task automatic cyc(input logic rst, input logic [2:0] ns, input logic [5:0] op,
                       input logic z, input logic st, input logic [2:0] e_state,
                       input logic [4:0] e_strb, input logic [1:0] e_src,
                       input logic e_wrd, input logic e_halt, input logic [31:0] e_ret);
        @(posedge CLK);
        #1;
        Reset      = rst;
        next_state = ns;
        opcode     = op;
        zero       = z;
        stall      = st;
        exp_q.push_back({e_state, e_strb, e_src, e_wrd, e_halt, e_ret});
        id_q.push_back(vec_n);
        vec_n++;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            m_id  = id_q.pop_front();
            m_act = {i_state, PCWre, IRWre, mRD, mWR, RegWre, PCSrc, WrRegDSrc, halted, retired};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL vec%0d: got st=%b strb=%b src=%b wrd=%b h=%b ret=%0d, want st=%b strb=%b src=%b wrd=%b h=%b ret=%0d",
                         m_id, m_act[43:41], m_act[40:36], m_act[35:34], m_act[33], m_act[32], m_act[31:0],
                         m_exp[43:41], m_exp[40:36], m_exp[35:34], m_exp[33], m_exp[32], m_exp[31:0]);
            end
        end
    end

    initial begin
        Reset = 1'b0; next_state = ST_ID; opcode = 6'b000000; zero = 1'b0; stall = 1'b0;
        // reset held two cycles
        cyc(1'b0, ST_ID,   6'b000000, 1'b0, 1'b0, ST_IF,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, ST_ID,   6'b000000, 1'b0, 1'b0, ST_IF,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        // add: IF -> ID -> aEXE -> aWB -> IF
        cyc(1'b1, ST_ID,   6'b000000, 1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_AEXE, 6'b000000, 1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_AWB,  6'b000000, 1'b0, 1'b0, ST_AEXE, 5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_IF,   6'b000000, 1'b0, 1'b0, ST_AWB,  5'b10001, 2'b00, 1'b0, 1'b0, 32'd0);
        // lw with a 3-cycle stall in MEM
        cyc(1'b1, ST_ID,   OP_LW,     1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_CEXE, OP_LW,     1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_MEM,  OP_LW,     1'b0, 1'b0, ST_CEXE, 5'b00000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_CWB,  OP_LW,     1'b0, 1'b1, ST_MEM,  5'b00000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_CWB,  OP_LW,     1'b0, 1'b1, ST_MEM,  5'b00000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_CWB,  OP_LW,     1'b0, 1'b1, ST_MEM,  5'b00000, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_CWB,  OP_LW,     1'b0, 1'b0, ST_MEM,  5'b00100, 2'b00, 1'b0, 1'b0, 32'd1);
        cyc(1'b1, ST_IF,   OP_LW,     1'b0, 1'b0, ST_CWB,  5'b10001, 2'b00, 1'b1, 1'b0, 32'd1);
        // beq taken, then beq not taken
        cyc(1'b1, ST_ID,   OP_BEQ,    1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd2);
        cyc(1'b1, ST_BEXE, OP_BEQ,    1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd2);
        cyc(1'b1, ST_IF,   OP_BEQ,    1'b1, 1'b0, ST_BEXE, 5'b10000, 2'b01, 1'b0, 1'b0, 32'd2);
        cyc(1'b1, ST_ID,   OP_BEQ,    1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd3);
        cyc(1'b1, ST_BEXE, OP_BEQ,    1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd3);
        cyc(1'b1, ST_IF,   OP_BEQ,    1'b0, 1'b0, ST_BEXE, 5'b10000, 2'b00, 1'b0, 1'b0, 32'd3);
        // jal completes in ID
        cyc(1'b1, ST_ID,   OP_JAL,    1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd4);
        cyc(1'b1, ST_IF,   OP_JAL,    1'b0, 1'b0, ST_ID,   5'b10001, 2'b11, 1'b0, 1'b0, 32'd4);
        // halt: parks in ID, no strobes, no retire
        cyc(1'b1, ST_ID,   OP_HALT,   1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd5);
        cyc(1'b1, ST_IF,   OP_HALT,   1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd5);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, ST_IF, OP_HALT, 1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b1, 32'd5);
        end
        // reset clears halt
        cyc(1'b0, ST_ID,   OP_HALT,   1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b1, 32'd5);
        // sw finishes in MEM after reset
        cyc(1'b1, ST_ID,   OP_SW,     1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_CEXE, OP_SW,     1'b0, 1'b0, ST_ID,   5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_MEM,  OP_SW,     1'b0, 1'b0, ST_CEXE, 5'b00000, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_IF,   OP_SW,     1'b0, 1'b0, ST_MEM,  5'b10010, 2'b00, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, ST_ID,   OP_SW,     1'b0, 1'b0, ST_IF,   5'b01000, 2'b00, 1'b0, 1'b0, 32'd1);
        // let the monitor drain, bounded
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
